// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: ALUOp classes, funct fields,
// ALUControl encodings and the handshake FSM states.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Base-ISA op selected by funct3 when funct7 carries no modifier.
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            F3_ADDSUB: op = OP_ADD;
            F3_SLL:    op = OP_SLL;
            F3_SLT:    op = OP_SLT;
            F3_SLTU:   op = OP_SLTU;
            F3_XOR:    op = OP_XOR;
            F3_SR:     op = OP_SRL;
            F3_OR:     op = OP_OR;
            default:   op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7 decoder producing the ALUControl code,
// M-extension/divide flags and the illegal-encoding flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int MEXT_EN = 1,
    localparam int CTRL_W = 4 + MEXT_EN
) (
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic [CTRL_W-1:0] code,
    output logic              is_mext,
    output logic              is_div,
    output logic              illegal
);

    always_comb begin
        code    = CTRL_W'(OP_ADD);
        is_mext = 1'b0;
        is_div  = 1'b0;
        illegal = 1'b0;
        case (ALUOp)
            ALUOP_LDST: code = CTRL_W'(OP_ADD);
            ALUOP_BR:   code = CTRL_W'(OP_SUB);
            ALUOP_R: begin
                if (funct7 == F7_BASE) begin
                    code = CTRL_W'(base_op(funct3));
                end else if (funct7 == F7_ALT && funct3 == F3_ADDSUB) begin
                    code = CTRL_W'(OP_SUB);
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    code = CTRL_W'(OP_SRA);
                end else if (funct7 == F7_MEXT && MEXT_EN != 0) begin
                    // M ops: MSB set, low bits are funct3 (bit 2 splits mul/div).
                    code    = CTRL_W'({2'b10, funct3});
                    is_mext = 1'b1;
                    is_div  = funct3[2];
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                if (funct3 == F3_SLL) begin
                    if (funct7 == F7_BASE) code = CTRL_W'(OP_SLL);
                    else                   illegal = 1'b1;
                end else if (funct3 == F3_SR) begin
                    if (funct7 == F7_BASE)     code = CTRL_W'(OP_SRL);
                    else if (funct7 == F7_ALT) code = CTRL_W'(OP_SRA);
                    else                       illegal = 1'b1;
                end else begin
                    code = CTRL_W'(base_op(funct3));
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control unit: decodes the op, registers it behind valid/ready, and holds
// the unit busy for the multiply/divide latency before presenting M-ext results.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MEXT_EN = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8,
    localparam int CTRL_W = 4 + MEXT_EN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              is_mext,
    output logic              illegal,
    output logic              busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [CTRL_W-1:0] dec_code;
    logic              dec_mext;
    logic              dec_div;
    logic              dec_ill;

    alu_ctrl_decode #(.MEXT_EN(MEXT_EN)) u_decode (
        .ALUOp   (ALUOp),
        .funct3  (funct3),
        .funct7  (funct7),
        .code    (dec_code),
        .is_mext (dec_mext),
        .is_div  (dec_div),
        .illegal (dec_ill)
    );

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [CTRL_W-1:0] code_q;
    logic              mext_q;
    logic              ill_q;
    logic              accept;

    assign in_ready   = (state_q == S_IDLE) || (state_q == S_HOLD && out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q == S_BUSY);
    assign out_valid  = out_valid_q;
    assign ALUControl = code_q;
    assign is_mext    = mext_q;
    assign illegal    = ill_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            mext_q      <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    // HOLD with out_ready behaves like IDLE so back-to-back ops stream.
                    if (accept) begin
                        code_q <= dec_code;
                        mext_q <= dec_mext;
                        ill_q  <= dec_ill;
                        if (dec_mext) begin
                            state_q     <= S_BUSY;
                            cnt_q       <= dec_div ? DIV_CNT : MUL_CNT;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= S_HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end else if (state_q == S_HOLD && out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q     <= S_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed vector table, hand-written handshake/latency
// sequences, and random traffic checked against a timestamp-based reference.
module tb_alu_ctrl_seq;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic       in_ready, out_valid, is_mext, illegal, busy;
    logic [4:0] ALUControl;
    logic       in_ready0, out_valid0, is_mext0, illegal0, busy0;
    logic [3:0] ALUControl0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.MEXT_EN(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready), .ALUControl(ALUControl),
        .is_mext(is_mext), .illegal(illegal), .busy(busy)
    );

    alu_ctrl_seq #(.MEXT_EN(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid0), .out_ready(1'b1), .ALUControl(ALUControl0),
        .is_mext(is_mext0), .illegal(illegal0), .busy(busy0)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference decode straight from the encoding rules.
    function automatic void ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, output logic [4:0] code,
                                    output logic mx, output logic il);
        logic [4:0] tbl [8];
        tbl  = '{5'd2, 5'd4, 5'd8, 5'd9, 5'd3, 5'd5, 5'd1, 5'd0};
        code = 5'd2;
        mx   = 1'b0;
        il   = 1'b0;
        if (op == 2'd1) code = 5'd6;
        else if (op == 2'd2) begin
            if (f7 == 7'h00) code = tbl[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) code = 5'd6;
            else if (f7 == 7'h20 && f3 == 3'd5) code = 5'd7;
            else if (f7 == 7'h01) begin code = 5'd16 + 5'(f3); mx = 1'b1; end
            else il = 1'b1;
        end else if (op == 2'd3) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) code = 5'd4; else il = 1'b1;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) code = 5'd5;
                else if (f7 == 7'h20) code = 5'd7;
                else il = 1'b1;
            end else code = tbl[f3];
        end
    endfunction

    // Reference: one op in flight, visible from edge index m_rdy onward.
    int         e = 0;
    int         m_rdy = 0;
    bit         m_v = 1'b0;
    logic [4:0] m_code = '0;
    logic       m_mx = 1'b0, m_il = 1'b0;
    logic [4:0] d_code;
    logic       d_mx, d_il;
    bit         cur_ov, cur_rdy;

    always @(posedge clk) begin
        cur_ov  = m_v && (e >= m_rdy);
        cur_rdy = !m_v || (cur_ov && out_ready);
        e++;
        if (!rst_n) begin
            m_v = 1'b0;
        end else begin
            if (cur_ov && out_ready) m_v = 1'b0;
            if (in_valid && cur_rdy) begin
                ref_dec(ALUOp, funct3, funct7, d_code, d_mx, d_il);
                m_v    = 1'b1;
                m_code = d_code;
                m_mx   = d_mx;
                m_il   = d_il;
                m_rdy  = e + (d_mx ? (funct3[2] ? DIV_LAT : MUL_LAT) : 0);
            end
        end
    end

    always @(negedge clk) begin
        bit exp_ov;
        exp_ov = m_v && (e >= m_rdy);
        chk("mdl_out_valid", 32'(out_valid), 32'(exp_ov));
        chk("mdl_busy", 32'(busy), 32'(m_v && (e < m_rdy)));
        chk("mdl_in_ready", 32'(in_ready), 32'(!m_v || (exp_ov && out_ready)));
        if (exp_ov) begin
            chk("mdl_code", 32'(ALUControl), 32'(m_code));
            chk("mdl_is_mext", 32'(is_mext), 32'(m_mx));
            chk("mdl_illegal", 32'(illegal), 32'(m_il));
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] code;
        logic       mx;
        logic       il;
    } vec_t;

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        in_valid = v;
        ALUOp    = op;
        funct3   = f3;
        funct7   = f7;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t strm [5];
        vec_t tbl [14];
        int   lat;
        bit   found;
        bit   seen;

        strm = '{
            '{2'd2, 3'd0, 7'h20, 5'b00110, 1'b0, 1'b0},
            '{2'd2, 3'd0, 7'h00, 5'b00010, 1'b0, 1'b0},
            '{2'd2, 3'd4, 7'h00, 5'b00011, 1'b0, 1'b0},
            '{2'd2, 3'd5, 7'h20, 5'b00111, 1'b0, 1'b0},
            '{2'd2, 3'd3, 7'h00, 5'b01001, 1'b0, 1'b0}
        };
        tbl = '{
            '{2'd2, 3'd0, 7'h02, 5'b00010, 1'b0, 1'b1},
            '{2'd3, 3'd1, 7'h20, 5'b00010, 1'b0, 1'b1},
            '{2'd2, 3'd2, 7'h20, 5'b00010, 1'b0, 1'b1},
            '{2'd3, 3'd5, 7'h20, 5'b00111, 1'b0, 1'b0},
            '{2'd3, 3'd0, 7'h7f, 5'b00010, 1'b0, 1'b0},
            '{2'd3, 3'd2, 7'h55, 5'b01000, 1'b0, 1'b0},
            '{2'd3, 3'd1, 7'h00, 5'b00100, 1'b0, 1'b0},
            '{2'd3, 3'd5, 7'h00, 5'b00101, 1'b0, 1'b0},
            '{2'd0, 3'd7, 7'h7f, 5'b00010, 1'b0, 1'b0},
            '{2'd1, 3'd3, 7'h01, 5'b00110, 1'b0, 1'b0},
            '{2'd2, 3'd7, 7'h00, 5'b00000, 1'b0, 1'b0},
            '{2'd2, 3'd6, 7'h00, 5'b00001, 1'b0, 1'b0},
            '{2'd2, 3'd6, 7'h01, 5'b10110, 1'b1, 1'b0},
            '{2'd2, 3'd3, 7'h01, 5'b10011, 1'b1, 1'b0}
        };

        // Reset held two edges with a request pending.
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1'b1, 2'd2, 3'd0, 7'h20);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_code", 32'(ALUControl), 32'd0);
        chk("rst_is_mext", 32'(is_mext), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Streaming non-M ops: one result per cycle.
        drive(1'b1, strm[0].op, strm[0].f3, strm[0].f7);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) drive(1'b1, strm[i+1].op, strm[i+1].f3, strm[i+1].f7);
            else       in_valid = 1'b0;
            @(negedge clk);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_code", 32'(ALUControl), 32'(strm[i].code));
        end
        step();

        // MUL: busy for MUL_LAT cycles, request while busy ignored.
        drive(1'b1, 2'd2, 3'd0, 7'h01);
        step();
        drive(1'b1, 2'd2, 3'd0, 7'h00);
        @(negedge clk);
        chk("mul_busy1", 32'(busy), 32'd1);
        chk("mul_nvalid1", 32'(out_valid), 32'd0);
        chk("mul_in_ready", 32'(in_ready), 32'd0);
        chk("m0_valid", 32'(out_valid0), 32'd1);
        chk("m0_illegal", 32'(illegal0), 32'd1);
        chk("m0_code", 32'(ALUControl0), 32'b0010);
        chk("m0_is_mext", 32'(is_mext0), 32'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mul_busy2", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_code", 32'(ALUControl), 32'b10000);
        chk("mul_is_mext", 32'(is_mext), 32'd1);
        chk("mul_busy_done", 32'(busy), 32'd0);
        step();

        // DIVU with backpressure on the result.
        out_ready = 1'b0;
        drive(1'b1, 2'd2, 3'd5, 7'h01);
        step();
        in_valid = 1'b0;
        lat = 0;
        found = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            if (n == 3) drive(1'b1, 2'd1, 3'd0, 7'h00);
            else if (n == 4) in_valid = 1'b0;
            step();
            lat = n;
            if (out_valid) found = 1'b1;
        end
        chk("divu_latency", 32'(lat), 32'(DIV_LAT));
        chk("divu_code", 32'(ALUControl), 32'b10101);
        chk("divu_is_mext", 32'(is_mext), 32'd1);
        drive(1'b1, 2'd1, 3'd0, 7'h00);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_code", 32'(ALUControl), 32'b10101);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_code", 32'(ALUControl), 32'b00110);
        chk("bp_next_mext", 32'(is_mext), 32'd0);
        step();

        // Vector table, one op at a time.
        foreach (tbl[k]) begin
            drive(1'b1, tbl[k].op, tbl[k].f3, tbl[k].f7);
            step();
            in_valid = 1'b0;
            found = 1'b0;
            for (int n = 0; n < 20 && !found; n++) begin
                @(negedge clk);
                if (out_valid) found = 1'b1;
            end
            chk("vec_seen", 32'(found), 32'd1);
            chk("vec_code", 32'(ALUControl), 32'(tbl[k].code));
            chk("vec_is_mext", 32'(is_mext), 32'(tbl[k].mx));
            chk("vec_illegal", 32'(illegal), 32'(tbl[k].il));
            step();
        end

        // Reset during the third cycle of a DIV.
        drive(1'b1, 2'd2, 3'd4, 7'h01);
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        step();

        // Random traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            in_valid  = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            ALUOp     = 2'($urandom_range(0, 3));
            funct3    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       funct7 = 7'h00;
                1:       funct7 = 7'h20;
                2:       funct7 = 7'h01;
                default: funct7 = 7'($urandom_range(0, 127));
            endcase
            step();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
